// File: rtl/piso_bit_serializer.sv
`default_nettype none
// ============================================================================
// Module   : piso_bit_serializer
// Purpose  : Parallel-in/serial-out feeder for the serial sequence detector.
//            Optional parity bit when SERIAL_PARITY_EN is defined.
// Revision : 1.0 - initial release
// ============================================================================
module piso_bit_serializer #(
  parameter int unsigned WIDTH      = 8,
  parameter bit          MSB_FIRST  = 1'b1,
  parameter bit          IDLE_BIT   = 1'b1,
  parameter int unsigned GAP_CYCLES = 0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] din,
  input  logic             din_valid,
  output logic             din_ready,
  output logic             x_out,
  output logic             x_valid,
  output logic             busy,
  output logic             frame_done
);

  localparam int unsigned c_CW = $clog2(WIDTH + 2);
`ifdef SERIAL_PARITY_EN
  localparam logic [c_CW-1:0] c_FRAME_LEN = c_CW'(WIDTH + 1);
`else
  localparam logic [c_CW-1:0] c_FRAME_LEN = c_CW'(WIDTH);
`endif
  localparam logic [7:0] c_GAP_LAST = (GAP_CYCLES > 0) ? 8'(GAP_CYCLES - 1) : 8'd0;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SHIFT = 2'd1,
    S_GAP   = 2'd2
  } state_t;

  state_t           r_state;
  logic [c_CW-1:0]  r_cnt;
  logic [7:0]       r_gap;
  logic [WIDTH-1:0] r_shift;

  logic             w_first_bit;
  logic [WIDTH-1:0] w_load_shift;
  logic             w_next_bit;
  logic             w_shift_bit;

  assign w_first_bit  = MSB_FIRST ? din[WIDTH-1] : din[0];
  assign w_load_shift = MSB_FIRST ? (din << 1) : (din >> 1);
  assign w_next_bit   = MSB_FIRST ? r_shift[WIDTH-1] : r_shift[0];

`ifdef SERIAL_PARITY_EN
  logic r_parity;
  // After the last data bit the counter equals WIDTH: that slot carries parity.
  assign w_shift_bit = (r_cnt == c_CW'(WIDTH)) ? r_parity : w_next_bit;
`else
  assign w_shift_bit = w_next_bit;
`endif

  assign din_ready = (r_state == S_IDLE);
  assign busy      = (r_state != S_IDLE);

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state    <= S_IDLE;
      r_cnt      <= '0;
      r_gap      <= 8'd0;
      r_shift    <= '0;
      x_out      <= IDLE_BIT;
      x_valid    <= 1'b0;
      frame_done <= 1'b0;
`ifdef SERIAL_PARITY_EN
      r_parity   <= 1'b0;
`endif
    end else begin
      case (r_state)
        S_IDLE: begin
          frame_done <= 1'b0;
          if (din_valid) begin
            r_shift <= w_load_shift;
            x_out   <= w_first_bit;
            x_valid <= 1'b1;
            r_cnt   <= c_CW'(1);
            r_state <= S_SHIFT;
`ifdef SERIAL_PARITY_EN
            r_parity <= ^din;
`endif
          end else begin
            x_out   <= IDLE_BIT;
            x_valid <= 1'b0;
          end
        end
        S_SHIFT: begin
          if (r_cnt < c_FRAME_LEN) begin
            r_cnt      <= r_cnt + c_CW'(1);
            r_shift    <= MSB_FIRST ? (r_shift << 1) : (r_shift >> 1);
            x_out      <= w_shift_bit;
            frame_done <= ((r_cnt + c_CW'(1)) == c_FRAME_LEN);
          end else begin
            x_out      <= IDLE_BIT;
            x_valid    <= 1'b0;
            frame_done <= 1'b0;
            r_cnt      <= '0;
            if (GAP_CYCLES > 0) begin
              r_gap   <= c_GAP_LAST;
              r_state <= S_GAP;
            end else begin
              r_state <= S_IDLE;
            end
          end
        end
        S_GAP: begin
          if (r_gap == 8'd0) begin
            r_state <= S_IDLE;
          end else begin
            r_gap <= r_gap - 8'd1;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_piso_bit_serializer.sv
`default_nettype none
// ============================================================================
// Module   : tb_piso_bit_serializer
// Purpose  : Randomised scoreboard bench for piso_bit_serializer over two
//            parameter sets; honours SERIAL_PARITY_EN.
// Revision : 1.0 - initial release
// ============================================================================
module tb_piso_bit_serializer;

  localparam int N_CYC   = 700;
  localparam int DRAIN_C = 660;
`ifdef SERIAL_PARITY_EN
  localparam int FL = 9;
`else
  localparam int FL = 8;
`endif

  typedef struct {
    bit b;
    bit last;
    int cyc;
  } exp_t;

  logic clk;
  int   n_checks = 0;
  int   n_fail   = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp_v);
    n_checks++;
    if (act !== exp_v) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at t=%0t", nm, act, exp_v, $time);
    end
  endtask

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_cfg
      localparam bit c_MSB  = (gi == 0);
      localparam bit c_IDLE = (gi == 0);
      localparam int c_GAP  = (gi == 0) ? 0 : 3;

      logic       rst;
      logic [7:0] din;
      logic       din_valid;
      logic       din_ready, x_out, x_valid, busy, frame_done;

      int   edge_cnt   = 0;
      int   ready_edge = 0;
      bit   exp_ready  = 1'b1;
      exp_t exp_q[$];

      piso_bit_serializer #(
        .WIDTH(8), .MSB_FIRST(c_MSB), .IDLE_BIT(c_IDLE), .GAP_CYCLES(c_GAP)
      ) u_dut (
        .clk(clk), .reset(rst), .din(din), .din_valid(din_valid),
        .din_ready(din_ready), .x_out(x_out), .x_valid(x_valid),
        .busy(busy), .frame_done(frame_done)
      );

      // Stimulus plus reference model: expected bits are queued on accept.
      initial begin : drv
        logic [7:0] dir_words [6];
        logic [7:0] w;
        bit         pending;
        int         widx;
        int         rst_at;
        dir_words[0] = 8'h60; dir_words[1] = 8'hA5; dir_words[2] = 8'h0F;
        dir_words[3] = 8'hF0; dir_words[4] = 8'h66; dir_words[5] = 8'h61;
        rst = 1'b1; din = 8'h00; din_valid = 1'b0;
        pending = 1'b0; widx = 0; rst_at = -1;
        @(negedge clk);
        for (int c = 0; c < N_CYC; c++) begin
          rst = (edge_cnt + 1 <= 2) || (edge_cnt + 1 == rst_at) ||
                (c > 80 && c < DRAIN_C && $urandom_range(0, 59) == 0);
          if (!pending) begin
            if (c >= DRAIN_C) begin
              din_valid = 1'b0;
              din = 8'($urandom);
            end else if (widx < 6) begin
              din = dir_words[widx];
              din_valid = 1'b1;
              pending = 1'b1;
              widx++;
            end else begin
              din = 8'($urandom);
              din_valid = ($urandom_range(0, 2) != 0);
              pending = din_valid;
            end
          end
          @(posedge clk);
          edge_cnt++;
          if (rst) begin
            exp_q.delete();
            ready_edge = edge_cnt + 1;
          end else if (din_valid && edge_cnt >= ready_edge) begin
            w = din;
            for (int k = 0; k < 8; k++) begin
              exp_t e;
              e.b    = c_MSB ? w[7-k] : w[k];
              e.last = (k == FL - 1);
              e.cyc  = edge_cnt + k;
              exp_q.push_back(e);
            end
`ifdef SERIAL_PARITY_EN
            begin
              exp_t p;
              p.b = ^w; p.last = 1'b1; p.cyc = edge_cnt + 8;
              exp_q.push_back(p);
            end
`endif
            ready_edge = edge_cnt + FL + c_GAP + 1;
            pending = 1'b0;
            if (w == 8'h66 && rst_at < 0) rst_at = edge_cnt + 4;
          end
          exp_ready = (edge_cnt + 1 >= ready_edge);
          @(negedge clk);
        end
      end

      // Monitor: compares DUT outputs mid-cycle against the scoreboard.
      initial begin : mon
        exp_t e;
        bit   due;
        @(posedge clk);
        forever begin
          @(negedge clk);
          chk($sformatf("cfg%0d din_ready", gi), din_ready, exp_ready);
          chk($sformatf("cfg%0d busy", gi), busy, !exp_ready);
          due = (exp_q.size() > 0) && (exp_q[0].cyc == edge_cnt);
          chk($sformatf("cfg%0d x_valid", gi), x_valid, due);
          if (due) begin
            e = exp_q.pop_front();
            chk($sformatf("cfg%0d x_out bit", gi), x_out, e.b);
            chk($sformatf("cfg%0d frame_done", gi), frame_done, e.last);
          end else begin
            chk($sformatf("cfg%0d x_out idle", gi), x_out, c_IDLE);
            chk($sformatf("cfg%0d frame_done idle", gi), frame_done, 1'b0);
          end
        end
      end
    end
  endgenerate

  initial begin : main
    repeat (N_CYC + 20) @(posedge clk);
    #1;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
